sar_conv_ctrl: RTL and testbench

Successive-approximation conversion controller for the time-domain SAR ADC. It is the responder side of the `start`/`eoc` handshake driven by the sample/start generator. On `start` it runs an NBITS binary search: it drives the DAC trial code and strobes the time-domain comparator through a four-phase `cmp_go`/`cmp_done` handshake. When the search finishes it presents the result and raises `eoc`.

---
 rtl/sar_conv_ctrl.sv | 114 +++++++++++
 tb/tb_sar_conv_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl: successive-approximation controller with a 4-phase cmp_go/cmp_done handshake.
// Define SAR_CMP_TIMEOUT_EN to add a comparator timeout that forces the bit to 1 and sets cmp_to.
module sar_conv_ctrl #(
  parameter int NBITS  = 8,
  parameter int TO_CYC = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             cmp_done,
  input  logic             cmp_out,
  output logic             cmp_go,
  output logic [NBITS-1:0] dac_code,
  output logic             eoc,
  output logic [NBITS-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             cmp_to
);
  localparam int KW = $clog2(NBITS);
  typedef enum logic [1:0] {IDLE, CMP, REL, DONE} state_t;
  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [NBITS-1:0] dac_q, dac_d, dout_q, dout_d;
  logic             go_q, eoc_q, dv_q, dv_d, to_q, to_d, tmo;
  logic [1:0]       done_sync_q, out_sync_q;
  logic             done_s, out_s;
  assign done_s = done_sync_q[1];
  assign out_s  = out_sync_q[1];
`ifdef SAR_CMP_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  assign tmo = cnt_q >= TW'(TO_CYC - 1);
  always_comb cnt_d = (state_d != state_q) ? '0 : tmo ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dac_d   = dac_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    to_d    = to_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CMP;
        k_d     = KW'(NBITS - 1);
        dac_d   = {1'b1, {(NBITS-1){1'b0}}};
      end
      CMP: if (done_s || tmo) begin
        state_d = REL;
        if (!done_s) to_d = 1'b1;
        else if (!out_s) dac_d[k_q] = 1'b0;
      end
      REL: if (!done_s || tmo) begin
        if (k_q == '0) begin
          state_d = DONE;
          dout_d  = dac_q;
          dv_d    = 1'b1;
        end else begin
          state_d              = CMP;
          k_d                  = k_q - 1'b1;
          dac_d[k_q - 1'b1]    = 1'b1;
        end
      end
      default: if (!start) state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      dac_d   = '0;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      to_d    = to_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      dac_q       <= '0;
      dout_q      <= '0;
      go_q        <= 1'b0;
      eoc_q       <= 1'b0;
      dv_q        <= 1'b0;
      to_q        <= 1'b0;
      done_sync_q <= '0;
      out_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      dac_q       <= dac_d;
      dout_q      <= dout_d;
      go_q        <= state_d == CMP;
      eoc_q       <= state_d == DONE;
      dv_q        <= dv_d;
      to_q        <= to_d;
      done_sync_q <= {done_sync_q[0], cmp_done};
      out_sync_q  <= {out_sync_q[0], cmp_out};
    end
  end
  assign cmp_go     = go_q;
  assign dac_code   = dac_q;
  assign eoc        = eoc_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign busy       = state_q != IDLE;
  assign cmp_to     = to_q;
endmodule

// File: tb/tb_sar_conv_ctrl.sv
// tb_sar_conv_ctrl: scoreboard bench; expected trial codes and results are queued at stimulus time
// and checked by a monitor whenever the DUT strobes cmp_go or pulses dout_valid.
module tb_sar_conv_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, silent = 1'b0;
  logic       cmp_done, cmp_out, cmp_go, eoc, dout_valid, busy, cmp_to;
  logic [7:0] dac_code, dout, vin = 8'h00;
  logic       go_prev = 1'b0;
  logic       eoc_seen;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] exp_trial[$], exp_dout[$];

  always #5 clk = ~clk;

  sar_conv_ctrl #(.NBITS(8), .TO_CYC(15)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cmp_done(cmp_done), .cmp_out(cmp_out),
    .cmp_go(cmp_go), .dac_code(dac_code), .eoc(eoc), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .cmp_to(cmp_to)
  );

  // comparator: done follows cmp_go one cycle later; Vin sits just above its own code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_done <= 1'b0;
      cmp_out  <= 1'b0;
    end else begin
      cmp_done <= cmp_go & ~silent;
      cmp_out  <= vin >= dac_code;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  always @(negedge clk) begin
    if (dout_valid) begin
      if (exp_dout.size() == 0) unexpected("dout_valid", dout);
      else chk("dout", dout, exp_dout.pop_front());
    end
    if (cmp_go && !go_prev) begin
      if (exp_trial.size() == 0) unexpected("trial", dac_code);
      else chk("trial", dac_code, exp_trial.pop_front());
    end
    go_prev = cmp_go;
  end

  task automatic push_model(input logic [7:0] v);
    logic [7:0] c, t;
    c = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      t = c | (8'h01 << k);
      exp_trial.push_back(t);
      if (v >= t) c = t;
    end
    exp_dout.push_back(c);
  endtask

  task automatic run(input logic [7:0] v, output int cyc);
    vin   = v;
    start = 1'b1;
    cyc   = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!eoc && cyc < 400);
  endtask

  task automatic conv(input logic [7:0] v, input logic [7:0] res);
    int cyc;
    run(v, cyc);
    chk("eoc_latency", cyc, 65);
    repeat (3) @(posedge clk);
    #1 chk("eoc_held", eoc, 1);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("eoc_drop", eoc, 0);
    chk("idle_busy", busy, 0);
    chk("dac_hold", dac_code, res);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmp_go", cmp_go, 0);
    chk("rst_dac", dac_code, 0);
    chk("rst_eoc", eoc, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmp_to", cmp_to, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Vin 0xA5, hand-computed trial sequence
    exp_trial = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    exp_dout.push_back(8'hA5);
    conv(8'hA5, 8'hA5);
    // abort during bit 4 with Vin 0x5A
    exp_trial = '{8'h80, 8'h40, 8'h60, 8'h50};
    vin   = 8'h5A;
    start = 1'b1;
    cyc   = 0;
    while (exp_trial.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("abort_reach_bit4", exp_trial.size(), 0);
    repeat (2) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cmp_go", cmp_go, 0);
    chk("abort_dac", dac_code, 0);
    chk("abort_busy", busy, 0);
    eoc_seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 eoc_seen |= eoc;
    end
    chk("abort_no_eoc", eoc_seen, 0);
    chk("abort_dout_kept", dout, 8'hA5);
    start = 1'b0;
    en    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    push_model(8'h00);
    conv(8'h00, 8'h00);
    push_model(8'hFF);
    conv(8'hFF, 8'hFF);
    // async reset in the middle of REL of the first bit
    exp_trial.push_back(8'h80);
    vin   = 8'h3C;
    start = 1'b1;
    cyc   = 0;
    while (!cmp_go && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    while (cmp_go && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reach_rel", cyc < 50, 1);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("arst_cmp_go", cmp_go, 0);
    chk("arst_dac", dac_code, 0);
    chk("arst_eoc", eoc, 0);
    chk("arst_dout", dout, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    push_model(8'h3C);
    conv(8'h3C, 8'h3C);
    // silent comparator
    silent = 1'b1;
`ifdef SAR_CMP_TIMEOUT_EN
    push_model(8'hFF);
    run(8'h00, cyc);
    chk("to_eoc", eoc, 1);
    chk("to_flag", cmp_to, 1);
    start = 1'b0;
`else
    exp_trial.push_back(8'h80);
    vin   = 8'h00;
    start = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("silent_cmp_go", cmp_go, 1);
    chk("silent_busy", busy, 1);
    chk("silent_eoc", eoc, 0);
    chk("silent_cmp_to", cmp_to, 0);
    en    = 1'b0;
    start = 1'b0;
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("trials_drained", exp_trial.size(), 0);
    chk("douts_drained", exp_dout.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
